// File: rtl/ex02_pkg.sv
// ---------------------------------------------------------------------------
// ex02_pkg
//   Shared constants and helpers for the vending-machine price encoder.
//   - DEF_WIDTH / DEF_MAX_PRICE : default price word width and highest legal price
//   - bcd_digit_t               : one BCD digit (0..9)
//   - SEG7_LUT                  : active-high a..g segment codes for digits 0..9
//                                 (bit 0 = segment a, bit 6 = segment g)
//   - bin_to_bcd()              : combinational compare-subtract binary -> two BCD digits
// ---------------------------------------------------------------------------
package ex02_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_MAX_PRICE = 15;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG7_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Repeatedly subtract ten; the loop bound covers the largest 7-bit value
  // (127 -> 12 subtractions), so the remainder is always below ten.
  // Returns {tens, ones}.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] value);
    logic [6:0] rem;
    bcd_digit_t tens;
    rem  = value;
    tens = '0;
    for (int i = 0; i < 12; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/ex02_seg7_dec.sv
// ---------------------------------------------------------------------------
// ex02_seg7_dec
//   Combinational BCD digit to seven-segment decoder (active-high a..g).
//   Non-decimal codes (10..15) produce a blank display.
//   Ports:
//     bcd  in  4  BCD digit
//     seg  out 7  segment code, bit 0 = a ... bit 6 = g
// ---------------------------------------------------------------------------
module ex02_seg7_dec
  import ex02_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    if (bcd <= 4'd9) begin
      seg = SEG7_LUT[bcd];
    end
  end

endmodule

// File: rtl/ex02_price_encoder.sv
// ---------------------------------------------------------------------------
// ex02_price_encoder
//   Vending-machine price encoder. Registers a price and presents it as a
//   binary word, a hex nibble and two BCD digits, one cycle after sampling.
//
//   Handshake: price_decimal is accepted on every rising edge where
//   price_valid=1 and rst_n=1. There is no backpressure. out_valid is high
//   for exactly the one cycle following each accepted sample; the data
//   outputs hold their last value while out_valid=0.
//
//   Parameters:
//     WIDTH      price word width, 4..7
//     MAX_PRICE  highest legal price (<= 2**WIDTH-1, <= 99)
//   Ports:
//     clk            in   1      rising-edge clock
//     rst_n          in   1      synchronous active-low reset
//     price_decimal  in   WIDTH  price to encode
//     price_valid    in   1      sample enable
//     price_binary   out  WIDTH  registered price
//     price_hex      out  4      low nibble of price_binary
//     bcd_tens       out  4      tens digit
//     bcd_ones       out  4      ones digit
//     out_valid      out  1      one-cycle pulse after each sample
//     out_of_range   out  1      sampled price > MAX_PRICE
//     seg_tens       out  7      (EX02_SEVSEG_EN only) tens segments, blank for 0
//     seg_ones       out  7      (EX02_SEVSEG_EN only) ones segments
//
//   Build option: define EX02_SEVSEG_EN to add the seven-segment outputs.
// ---------------------------------------------------------------------------
module ex02_price_encoder
  import ex02_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_PRICE = DEF_MAX_PRICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] price_decimal,
  input  logic             price_valid,
  output logic [WIDTH-1:0] price_binary,
  output logic [3:0]       price_hex,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             out_valid,
`ifdef EX02_SEVSEG_EN
  output logic [6:0]       seg_tens,
  output logic [6:0]       seg_ones,
`endif
  output logic             out_of_range
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_PRICE);

  logic [7:0] bcd_next;
  logic       oor_next;

  // Conversion happens on the incoming value so the digits land in the
  // output registers together with the binary word.
  assign bcd_next = bin_to_bcd(7'(price_decimal));
  assign oor_next = (price_decimal > MAX_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      price_binary <= '0;
      bcd_tens     <= '0;
      bcd_ones     <= '0;
      out_valid    <= 1'b0;
      out_of_range <= 1'b0;
    end else begin
      out_valid <= price_valid;
      if (price_valid) begin
        price_binary <= price_decimal;
        bcd_tens     <= bcd_next[7:4];
        bcd_ones     <= bcd_next[3:0];
        out_of_range <= oor_next;
      end
    end
  end

  assign price_hex = price_binary[3:0];

`ifdef EX02_SEVSEG_EN
  logic [6:0] seg_tens_dec;
  logic [6:0] seg_ones_dec;
  logic [6:0] seg_tens_next;

  ex02_seg7_dec u_dec_tens (
    .bcd (bcd_next[7:4]),
    .seg (seg_tens_dec)
  );

  ex02_seg7_dec u_dec_ones (
    .bcd (bcd_next[3:0]),
    .seg (seg_ones_dec)
  );

  // Leading-zero suppression: a zero tens digit is shown blank.
  assign seg_tens_next = (bcd_next[7:4] == 4'd0) ? 7'h00 : seg_tens_dec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_tens <= 7'h00;
      seg_ones <= 7'h00;
    end else if (price_valid) begin
      seg_tens <= seg_tens_next;
      seg_ones <= seg_ones_dec;
    end
  end
`endif

endmodule

// File: tb/tb_ex02_price_encoder.sv
// ---------------------------------------------------------------------------
// tb_ex02_price_encoder
//   Directed bench for ex02_price_encoder with a scoreboard queue. The driver
//   pushes hand-computed expected outputs for every accepted sample; the
//   monitor compares on the falling edge whenever out_valid is high, and
//   otherwise checks that outputs hold (or are cleared after a reset edge).
// ---------------------------------------------------------------------------
module tb_ex02_price_encoder;

`ifdef EX02_SEVSEG_EN
  localparam int W = 31;
`else
  localparam int W = 17;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] price_decimal;
  logic       price_valid;
  logic [3:0] price_binary;
  logic [3:0] price_hex;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       out_valid;
  logic       out_of_range;
`ifdef EX02_SEVSEG_EN
  logic [6:0] seg_tens;
  logic [6:0] seg_ones;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] hold_val;
  logic [W-1:0] act_val;
  logic         started;
  logic         rst_at_edge;
  int           checks;
  int           errors;

  ex02_price_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .price_decimal (price_decimal),
    .price_valid   (price_valid),
    .price_binary  (price_binary),
    .price_hex     (price_hex),
    .bcd_tens      (bcd_tens),
    .bcd_ones      (bcd_ones),
    .out_valid     (out_valid),
`ifdef EX02_SEVSEG_EN
    .seg_tens      (seg_tens),
    .seg_ones      (seg_ones),
`endif
    .out_of_range  (out_of_range)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- output packing ----------------
  always_comb begin
`ifdef EX02_SEVSEG_EN
    act_val = {out_of_range, price_binary, price_hex, bcd_tens, bcd_ones, seg_tens, seg_ones};
`else
    act_val = {out_of_range, price_binary, price_hex, bcd_tens, bcd_ones};
`endif
  end

  // ---------------- driver ----------------
  // Hand-computed expectations: binary, hex, tens, ones, tens/ones segments.
  task automatic drive(input logic v, input logic r, input logic [3:0] p,
                       input logic [3:0] e_bin, input logic [3:0] e_hex,
                       input logic [3:0] e_t, input logic [3:0] e_o,
                       input logic [6:0] e_st, input logic [6:0] e_so);
    logic [W-1:0] e;
    @(negedge clk);
    #1;
    price_valid   = v;
    rst_n         = r;
    price_decimal = p;
`ifdef EX02_SEVSEG_EN
    e = {1'b0, e_bin, e_hex, e_t, e_o, e_st, e_so};
`else
    e = {1'b0, e_bin, e_hex, e_t, e_o};
    if (e_st != e_so) e = e;
`endif
    if (v && r) exp_q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] p);
    drive(1'b0, 1'b1, p, 4'h0, 4'h0, 4'h0, 4'h0, 7'h00, 7'h00);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    rst_at_edge = !rst_n;
  end

  always @(negedge clk) begin
    if (rst_at_edge) started = 1'b1;
    if (started) begin
      checks++;
      if (out_valid) begin
        if (rst_at_edge) begin
          errors++;
          $display("FAIL reset_out_valid: got out_valid=1 want 0");
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got out_valid=1 with no pending sample, data=%h", act_val);
        end else begin
          hold_val = exp_q.pop_front();
          if (act_val !== hold_val) begin
            errors++;
            $display("FAIL sample_data: got %h want %h", act_val, hold_val);
          end
        end
      end else if (rst_at_edge) begin
        hold_val = '0;
        if (act_val !== '0) begin
          errors++;
          $display("FAIL reset_clear: got %h want 0", act_val);
        end
      end else begin
        if (act_val !== hold_val) begin
          errors++;
          $display("FAIL hold: got %h want %h", act_val, hold_val);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks        = 0;
    errors        = 0;
    started       = 1'b0;
    rst_at_edge   = 1'b0;
    hold_val      = '0;
    rst_n         = 1'b0;
    price_valid   = 1'b0;
    price_decimal = 4'd0;

    // Reset held for two cycles with a valid price present.
    drive(1'b1, 1'b0, 4'd9, 4'd9, 4'h9, 4'd0, 4'd9, 7'h00, 7'h6F);
    drive(1'b1, 1'b0, 4'd9, 4'd9, 4'h9, 4'd0, 4'd9, 7'h00, 7'h6F);
    idle(4'd0);

    // Single sample, then out_valid must drop and data hold.
    drive(1'b1, 1'b1, 4'd5, 4'b0101, 4'h5, 4'd0, 4'd5, 7'h00, 7'h6D);
    idle(4'd5);
    idle(4'd5);

    // Back-to-back samples including the all-ones word.
    drive(1'b1, 1'b1, 4'd10, 4'b1010, 4'hA, 4'd1, 4'd0, 7'h06, 7'h3F);
    drive(1'b1, 1'b1, 4'd15, 4'b1111, 4'hF, 4'd1, 4'd5, 7'h06, 7'h6D);
    idle(4'd0);

    // Low values, then hold with a different price on the bus.
    drive(1'b1, 1'b1, 4'd0, 4'b0000, 4'h0, 4'd0, 4'd0, 7'h00, 7'h3F);
    drive(1'b1, 1'b1, 4'd1, 4'b0001, 4'h1, 4'd0, 4'd1, 7'h00, 7'h06);
    drive(1'b1, 1'b1, 4'd7, 4'b0111, 4'h7, 4'd0, 4'd7, 7'h00, 7'h07);
    idle(4'd3);
    idle(4'd3);

    // Reset while valid: sample discarded, outputs cleared.
    drive(1'b1, 1'b0, 4'd12, 4'd12, 4'hC, 4'd1, 4'd2, 7'h06, 7'h5B);
    idle(4'd12);

    // Resume after reset.
    drive(1'b1, 1'b1, 4'd12, 4'b1100, 4'hC, 4'd1, 4'd2, 7'h06, 7'h5B);
    drive(1'b1, 1'b1, 4'd14, 4'b1110, 4'hE, 4'd1, 4'd4, 7'h06, 7'h66);
    drive(1'b1, 1'b1, 4'd9,  4'b1001, 4'h9, 4'd0, 4'd9, 7'h00, 7'h6F);

    // Sample followed immediately by reset: the registered value is wiped.
    drive(1'b1, 1'b1, 4'd11, 4'b1011, 4'hB, 4'd1, 4'd1, 7'h06, 7'h06);
    drive(1'b0, 1'b0, 4'd0,  4'd0, 4'h0, 4'd0, 4'd0, 7'h00, 7'h00);
    idle(4'd0);
    idle(4'd0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
